// File: rtl/led_pwm_array_if.sv
// Duty-cycle write bus for led_pwm_array: one write strobe carrying a channel
// index and a duty value.
interface led_pwm_array_if #(
    parameter int unsigned NUM_LEDS = 3,
    parameter int unsigned PWM_BITS = 8
);
    localparam int unsigned SelW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    logic [PWM_BITS-1:0] duty_wdata;
    logic [SelW-1:0]     duty_sel;
    logic                duty_valid;

    modport master (
        output duty_wdata,
        output duty_sel,
        output duty_valid
    );

    modport slave (
        input duty_wdata,
        input duty_sel,
        input duty_valid
    );
endinterface

// File: rtl/led_pwm_array.sv
// LED output stage: stretched core reset plus NUM_LEDS registered LED pins with
// per-channel PWM brightness. Duty writes are held pending and copied to the
// active set on the last counter value of a period, so a period never mixes duties.
// Build option: define LED_PWM_ARRAY_PWM_EN for the PWM path; without it the LEDs
// are plain registered copies of led_in_i and period_start_o is tied low.
module led_pwm_array #(
    parameter int unsigned         NUM_LEDS    = 3,
    parameter int unsigned         PWM_BITS    = 8,
    parameter bit                  ACTIVE_LOW  = 1'b1,
    parameter int unsigned         RST_STRETCH = 2,
    parameter logic [PWM_BITS-1:0] DUTY_INIT   = '1
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic                core_reset_o,
    input  logic [NUM_LEDS-1:0] led_in_i,
    led_pwm_array_if.slave      duty_if,
    output logic                period_start_o,
    output logic [NUM_LEDS-1:0] led_o
);
    localparam int unsigned StretchW = (RST_STRETCH > 0) ? $clog2(RST_STRETCH + 1) : 1;
    localparam logic [StretchW-1:0] StretchInit = StretchW'(RST_STRETCH);
    localparam logic [NUM_LEDS-1:0] LedDark = {NUM_LEDS{ACTIVE_LOW}};

    logic [StretchW-1:0] stretch_q, stretch_d;
    logic                core_reset_q, core_reset_d;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic [NUM_LEDS-1:0] lit;
    logic                running;

    // Core is released once the stretch count has drained.
    assign running = !core_reset_q;

    // Stretch countdown: core_reset stays high while the count is non-zero.
    always_comb begin
        stretch_d    = stretch_q;
        core_reset_d = 1'b0;
        if (stretch_q != '0) begin
            stretch_d    = stretch_q - StretchW'(1);
            core_reset_d = 1'b1;
        end
    end

    // Stretch state; reset re-arms the full stretch.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stretch_q    <= StretchInit;
            core_reset_q <= 1'b1;
        end else begin
            stretch_q    <= stretch_d;
            core_reset_q <= core_reset_d;
        end
    end

`ifdef LED_PWM_ARRAY_PWM_EN
    localparam logic [PWM_BITS-1:0] CntMax = '1;

    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PWM_BITS-1:0] active_q [NUM_LEDS];
    logic [PWM_BITS-1:0] active_d [NUM_LEDS];
    logic [PWM_BITS-1:0] pending_q[NUM_LEDS];
    logic [PWM_BITS-1:0] pending_d[NUM_LEDS];
    logic [NUM_LEDS-1:0] flag_q, flag_d;
    logic                period_start_q, period_start_d;
    logic                boundary;
    logic                wr_ok;

    assign boundary = running && (cnt_q == CntMax);
    // Out-of-range channel indices are dropped here.
    assign wr_ok    = running && duty_if.duty_valid &&
                      (int'(duty_if.duty_sel) < int'(NUM_LEDS));

    // Counter advance, pending capture and boundary copy to the active duties.
    always_comb begin
        cnt_d     = running ? cnt_q + PWM_BITS'(1) : cnt_q;
        active_d  = active_q;
        pending_d = pending_q;
        flag_d    = flag_q;
        for (int i = 0; i < int'(NUM_LEDS); i++) begin
            if (boundary && flag_q[i]) begin
                active_d[i] = pending_q[i];
                flag_d[i]   = 1'b0;
            end
            if (wr_ok && (int'(duty_if.duty_sel) == i)) begin
                pending_d[i] = duty_if.duty_wdata;
                if (boundary) begin
                    // Write on the last cycle of a period is due at the very next 0.
                    active_d[i] = duty_if.duty_wdata;
                    flag_d[i]   = 1'b0;
                end else begin
                    flag_d[i] = 1'b1;
                end
            end
        end
    end

    // Per-channel lit decision; all-ones duty means continuously on.
    always_comb begin
        lit = '0;
        for (int i = 0; i < int'(NUM_LEDS); i++) begin
            lit[i] = led_in_i[i] && ((active_q[i] == CntMax) || (cnt_q < active_q[i]));
        end
        period_start_d = running && (cnt_q == '0);
    end

    // PWM state registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q          <= '0;
            flag_q         <= '0;
            period_start_q <= 1'b0;
            for (int i = 0; i < int'(NUM_LEDS); i++) begin
                active_q[i]  <= DUTY_INIT;
                pending_q[i] <= DUTY_INIT;
            end
        end else begin
            cnt_q          <= cnt_d;
            flag_q         <= flag_d;
            period_start_q <= period_start_d;
            active_q       <= active_d;
            pending_q      <= pending_d;
        end
    end

    assign period_start_o = period_start_q;
`else
    logic                unused_duty;
    logic [PWM_BITS-1:0] unused_init;

    assign unused_duty = ^{duty_if.duty_wdata, duty_if.duty_sel, duty_if.duty_valid};
    assign unused_init = DUTY_INIT;

    // Without PWM a requested LED is simply on.
    always_comb begin
        lit = led_in_i;
    end

    assign period_start_o = 1'b0;
`endif

    // LED pins are dark while the core is held in reset.
    always_comb begin
        led_d = core_reset_q ? LedDark : (lit ^ LedDark);
    end

    // Output register for the LED pins.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            led_q <= LedDark;
        end else begin
            led_q <= led_d;
        end
    end

    assign core_reset_o = core_reset_q;
    assign led_o        = led_q;
endmodule

// File: tb/tb_led_pwm_array.sv
// Bench for led_pwm_array (NUM_LEDS=3, PWM_BITS=8, ACTIVE_LOW=1, RST_STRETCH=2).
// Expected outputs come from a period-index model: edges since reset release give
// the counter value and period number; a write lands in the period after it occurs.
module tb_led_pwm_array;
    localparam logic [2:0] Dark = 3'b111;
    localparam int         Rs   = 2;
`ifdef LED_PWM_ARRAY_PWM_EN
    localparam bit PwmEn = 1'b1;
`else
    localparam bit PwmEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] led_in = 3'b000;
    logic       core_reset;
    logic       period_start;
    logic [2:0] led;

    led_pwm_array_if #(.NUM_LEDS(3), .PWM_BITS(8)) dif ();

    led_pwm_array #(
        .NUM_LEDS   (3),
        .PWM_BITS   (8),
        .ACTIVE_LOW (1'b1),
        .RST_STRETCH(2),
        .DUTY_INIT  (8'hFF)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .core_reset_o  (core_reset),
        .led_in_i      (led_in),
        .duty_if       (dif),
        .period_start_o(period_start),
        .led_o         (led)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    int         since = -1;
    int         m_k   = -1;
    int         act[3];
    int         pend[3];
    int         pend_per[3];
    bit         pend_v[3];
    logic       exp_cr;
    logic [2:0] exp_led;
    logic       exp_ps;

    function automatic void model_edge();
        int t;
        int p;
        bit on;
        if (!reset_n) begin
            since   = -1;
            m_k     = -1;
            exp_cr  = 1'b1;
            exp_led = Dark;
            exp_ps  = 1'b0;
            for (int c = 0; c < 3; c++) begin
                act[c]    = 255;
                pend_v[c] = 1'b0;
            end
            return;
        end
        since  = since + 1;
        exp_cr = (since < Rs);
        if (since < Rs + 1) begin
            m_k     = -1;
            exp_led = Dark;
            exp_ps  = 1'b0;
            return;
        end
        t   = since - Rs - 1;
        m_k = t % 256;
        p   = t / 256;
        for (int c = 0; c < 3; c++) begin
            if (pend_v[c] && p >= pend_per[c]) begin
                act[c]    = pend[c];
                pend_v[c] = 1'b0;
            end
            on         = !PwmEn || act[c] == 255 || m_k < act[c];
            exp_led[c] = (led_in[c] && on) ^ Dark[c];
        end
        exp_ps = PwmEn && (m_k == 0);
        if (dif.duty_valid && int'(dif.duty_sel) < 3) begin
            pend[int'(dif.duty_sel)]     = int'(dif.duty_wdata);
            pend_per[int'(dif.duty_sel)] = p + 1;
            pend_v[int'(dif.duty_sel)]   = 1'b1;
        end
    endfunction

    task automatic fail_line(input string name, input string got, input string want);
        n_fail++;
        if (n_fail <= 30) $display("FAIL %s: got %s, expected %s", name, got, want);
    endtask

    task automatic check_model();
        n_tests++;
        if (core_reset !== exp_cr || led !== exp_led || period_start !== exp_ps)
            fail_line($sformatf("model@since%0d", since),
                      $sformatf("cr=%b led=%b ps=%b", core_reset, led, period_start),
                      $sformatf("cr=%b led=%b ps=%b", exp_cr, exp_led, exp_ps));
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_tests++;
        if (got != want) fail_line(name, $sformatf("%0d", got), $sformatf("%0d", want));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic set_write(input int sel, input int data);
        dif.duty_valid = 1'b1;
        dif.duty_sel   = 2'(sel);
        dif.duty_wdata = 8'(data);
    endtask

    task automatic wait_k(input int target);
        for (int i = 0; i < 300; i++) begin
            if (m_k == target) return;
            tick();
        end
        check_int("wait_k_timeout", m_k, target);
    endtask

    task automatic wait_ps();
        for (int i = 0; i < 300; i++) begin
            tick();
            if (period_start === 1'b1) return;
        end
        check_int("wait_ps_timeout", 0, 1);
    endtask

    // Counts lit cycles per channel over n cycles, starting with the current one.
    task automatic count_lit(input int n, output int c0, output int c1, output int c2);
        c0 = 0;
        c1 = 0;
        c2 = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) tick();
            if (led[0] === 1'b0) c0++;
            if (led[1] === 1'b0) c1++;
            if (led[2] === 1'b0) c2++;
        end
    endtask

    typedef struct {
        logic       rst_n;
        logic [2:0] led_in;
        logic       cr;
        logic [2:0] led;
        logic       ps;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int c0, c1, c2, unl;
        logic [7:0] r;
        dif.duty_valid = 1'b0;
        dif.duty_sel   = 2'd0;
        dif.duty_wdata = 8'd0;

        for (int i = 0; i < 5; i++) vecs[i] = '{1'b0, 3'b101, 1'b1, 3'b111, 1'b0};
        vecs[5]  = '{1'b1, 3'b101, 1'b1, 3'b111, 1'b0};
        vecs[6]  = '{1'b1, 3'b101, 1'b1, 3'b111, 1'b0};
        vecs[7]  = '{1'b1, 3'b101, 1'b0, 3'b111, 1'b0};
        vecs[8]  = '{1'b1, 3'b101, 1'b0, 3'b010, 1'b1};
        vecs[9]  = '{1'b1, 3'b101, 1'b0, 3'b010, 1'b0};
        vecs[10] = '{1'b1, 3'b111, 1'b0, 3'b000, 1'b0};
        vecs[11] = '{1'b1, 3'b000, 1'b0, 3'b111, 1'b0};
        vecs[12] = '{1'b1, 3'b010, 1'b0, 3'b101, 1'b0};
        vecs[13] = '{1'b1, 3'b010, 1'b0, 3'b101, 1'b0};

        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            reset_n = vecs[i].rst_n;
            led_in  = vecs[i].led_in;
            tick();
            n_tests++;
            if (core_reset !== vecs[i].cr || led !== vecs[i].led ||
                period_start !== (vecs[i].ps & PwmEn))
                fail_line($sformatf("vec%0d", i),
                          $sformatf("cr=%b led=%b ps=%b", core_reset, led, period_start),
                          $sformatf("cr=%b led=%b ps=%b", vecs[i].cr, vecs[i].led,
                                    vecs[i].ps & PwmEn));
        end

`ifdef LED_PWM_ARRAY_PWM_EN
        // Duty 64 on ch1: lit for the first 64 cycles of each period.
        set_write(1, 64);
        tick();
        dif.duty_valid = 1'b0;
        wait_ps();
        check_int("ratio_lit_at_start", int'(led[1] === 1'b0), 1);
        count_lit(256, c0, c1, c2);
        check_int("ratio_ch1", c1, 64);

        // Write at counter 10 is deferred to the next period.
        led_in = 3'b001;
        wait_k(9);
        set_write(0, 200);
        tick();
        dif.duty_valid = 1'b0;
        unl = 0;
        for (int i = 0; i < 300 && m_k != 255; i++) begin
            tick();
            if (led[0] !== 1'b0) unl++;
        end
        check_int("deferred_old_holds", unl, 0);
        tick();
        check_int("deferred_ps", int'(period_start), 1);
        count_lit(256, c0, c1, c2);
        check_int("deferred_ch0_200", c0, 200);

        // Write on the boundary cycle is effective at the very next 0; duty 0 is off.
        wait_k(254);
        set_write(0, 0);
        tick();
        dif.duty_valid = 1'b0;
        tick();
        check_int("boundary_write_dark", int'(led[0]), 1);
        count_lit(256, c0, c1, c2);
        check_int("duty0_ch0", c0, 0);

        // Duty 255 is fully on.
        set_write(0, 255);
        tick();
        dif.duty_valid = 1'b0;
        wait_ps();
        count_lit(256, c0, c1, c2);
        check_int("duty255_ch0", c0, 256);

        // Out-of-range channel write changes nothing.
        led_in = 3'b011;
        set_write(3, 0);
        tick();
        dif.duty_valid = 1'b0;
        wait_ps();
        count_lit(256, c0, c1, c2);
        check_int("sel3_ch0", c0, 256);
        check_int("sel3_ch1", c1, 64);

        // Reset mid-period with a pending write: everything returns to DUTY_INIT.
        wait_k(98);
        set_write(2, 5);
        tick();
        dif.duty_valid = 1'b0;
        reset_n = 1'b0;
        tick();
        check_int("midrst_led_dark", int'(led), 7);
        check_int("midrst_core_reset", int'(core_reset), 1);
        reset_n = 1'b1;
        led_in  = 3'b110;
        wait_ps();
        count_lit(256, c0, c1, c2);
        check_int("midrst_ch1_init", c1, 256);
        check_int("midrst_ch2_discard", c2, 256);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset_n        = ($urandom_range(0, 599) != 0);
            led_in         = 3'($urandom);
            dif.duty_valid = ($urandom_range(0, 5) == 0);
            dif.duty_sel   = 2'($urandom_range(0, 3));
            r              = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       dif.duty_wdata = 8'd0;
                1:       dif.duty_wdata = 8'd255;
                default: dif.duty_wdata = r;
            endcase
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
